instr_fetch_unit: RTL and testbench

Instruction fetch front end that consumes the program counter's address stream and drives the instruction-memory request/response interface. It holds the fetch PC, issues word-aligned reads with a request/grant handshake, and buffers in-order responses in a 2-entry queue. It presents each instruction with its PC to decode over a valid/ready handshake. Branch/jump redirects flush the queue and discard in-flight responses.

---
 rtl/instr_fetch_unit.sv | 93 +++++++++
 tb/tb_instr_fetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues word-aligned imem reads under a 2-slot credit,
// tags in-flight PCs, buffers responses in a 2-entry queue and hands them to decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc
);

  logic [31:0] fetch_pc;
  logic [1:0]  outstanding;
  logic [1:0]  drop;
  logic [1:0]  count;
  logic        rd_ptr;
  logic        pq_rd;
  logic        pq_wr;

  logic [31:0] pq_pc      [2];
  logic [31:0] fifo_instr [2];
  logic [31:0] fifo_pc    [2];

  logic        credit;
  logic        grant;
  logic        resp;
  logic        push;
  logic        pop;
  logic        wr_ptr;
  logic [2:0]  occupancy;

  // Credit is built from registered state only so instr_ready never reaches imem_req.
  assign occupancy = {1'b0, outstanding} + {1'b0, count};
  assign credit    = occupancy < 3'd2;
  assign imem_req  = credit && !redirect_valid && rst;
  assign imem_addr = fetch_pc;

  assign grant  = imem_req && imem_gnt;
  assign resp   = imem_rvalid && (outstanding != 2'd0);
  assign push   = resp && (drop == 2'd0) && !redirect_valid;
  assign pop    = instr_valid && instr_ready;
  assign wr_ptr = rd_ptr ^ count[0];

  assign instr_valid = (count != 2'd0);
  assign instr_out   = instr_valid ? fifo_instr[rd_ptr] : 32'h0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]    : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= 2'd0;
      drop        <= 2'd0;
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      pq_rd       <= 1'b0;
      pq_wr       <= 1'b0;
    end else begin
      outstanding <= outstanding + {1'b0, grant} - {1'b0, resp};
      if (grant) pq_wr <= ~pq_wr;
      if (resp)  pq_rd <= ~pq_rd;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        count    <= 2'd0;
        // Everything still in flight, minus a response landing right now, is stale.
        drop     <= outstanding - {1'b0, resp};
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (resp && (drop != 2'd0)) drop <= drop - 2'd1;
        count <= count + {1'b0, push} - {1'b0, pop};
        if (pop) rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (grant) pq_pc[pq_wr] <= fetch_pc;
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= pq_pc[pq_rd];
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, async-reset sequence and
// randomized traffic checked against a program-order reference model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;

  int n_checks;
  int n_fail;

  instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ipc;
    logic [31:0] iout;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  task automatic drive_idle();
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    instr_ready    = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  logic [31:0] mq[$];
  logic [31:0] exp_fetch;
  logic [31:0] exp_pc;
  logic        pv, pr, prd;
  logic [31:0] pout, ppc;
  int          hs_count;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    drive_idle();
    rst = 1'b0;

    // reset, first fetch, backpressure, redirect with stale responses, simultaneous
    // redirect/response/handshake, wrap at the top of the address space
    vecs[0]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0,         32'h0};
    vecs[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0050_0093, 1'b0, 1'b1, 32'h0000_0104, 1'b0, 32'h0,         32'h0};
    vecs[2]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0108, 1'b1, 32'h0000_0100, 32'h0050_0093};
    vecs[3]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0108, 1'b1, 32'h0000_0100, 32'h0050_0093};
    vecs[4]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0060_0113, 1'b0, 1'b0, 32'h0000_0108, 1'b1, 32'h0000_0100, 32'h0050_0093};
    vecs[5]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0108, 1'b1, 32'h0000_0100, 32'h0050_0093};
    vecs[6]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0108, 1'b1, 32'h0000_0100, 32'h0050_0093};
    vecs[7]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0108, 1'b1, 32'h0000_0104, 32'h0060_0113};
    vecs[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0108, 1'b0, 32'h0,         32'h0};
    vecs[9]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_010C, 1'b0, 32'h0,         32'h0};
    vecs[10] = '{1'b1, 32'h0000_2003, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0110, 1'b0, 32'h0,         32'h0};
    vecs[11] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hDEAD_0001, 1'b1, 1'b0, 32'h0000_2000, 1'b0, 32'h0,         32'h0};
    vecs[12] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hDEAD_0002, 1'b1, 1'b1, 32'h0000_2000, 1'b0, 32'h0,         32'h0};
    vecs[13] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0070_0193, 1'b0, 1'b1, 32'h0000_2004, 1'b0, 32'h0,         32'h0};
    vecs[14] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_2004, 1'b1, 32'h0000_2000, 32'h0070_0193};
    vecs[15] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_2004, 1'b1, 32'h0000_2000, 32'h0070_0193};
    vecs[16] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'hBAD0_0003, 1'b1, 1'b0, 32'h0000_2008, 1'b1, 32'h0000_2000, 32'h0070_0193};
    vecs[17] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         32'h0};
    vecs[18] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h1111_1111, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0,         32'h0};
    vecs[19] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 32'h1111_1111};
    vecs[20] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 32'h1111_1111};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   imem_req,    32'd0);
    chk("rst_valid", instr_valid, 32'd0);
    chk("rst_addr",  imem_addr,   32'h0000_0100);
    chk("rst_out",   instr_out,   32'h0);
    chk("rst_pc",    instr_pc,    32'h0);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      imem_gnt       = vecs[i].gnt;
      imem_rvalid    = vecs[i].rvalid;
      imem_rdata     = vecs[i].rdata;
      instr_ready    = vecs[i].ready;
      @(negedge clk);
      chk($sformatf("v%0d_req", i),   imem_req,    {31'd0, vecs[i].req});
      chk($sformatf("v%0d_addr", i),  imem_addr,   vecs[i].addr);
      chk($sformatf("v%0d_valid", i), instr_valid, {31'd0, vecs[i].iv});
      chk($sformatf("v%0d_pc", i),    instr_pc,    vecs[i].ipc);
      chk($sformatf("v%0d_out", i),   instr_out,   vecs[i].iout);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-stream: one request outstanding, one instruction queued.
    drive_idle();
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", instr_valid, 32'd0);
    chk("arst_req",   imem_req,    32'd0);
    chk("arst_addr",  imem_addr,   32'h0000_0100);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rel_req",  imem_req,  32'd1);
    chk("rel_addr", imem_addr, 32'h0000_0100);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    #1;
    chk("late_rvalid_valid", instr_valid, 32'd0);
    chk("late_rvalid_req",   imem_req,    32'd1);
    imem_gnt = 1'b1;
    @(posedge clk);
    #1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00A0_0513;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    #1;
    chk("restart_valid", instr_valid, 32'd1);
    chk("restart_pc",    instr_pc,    32'h0000_0100);
    chk("restart_out",   instr_out,   32'h00A0_0513);
    chk("restart_addr",  imem_addr,   32'h0000_0104);

    // Randomized traffic against a program-order model.
    do_reset();
    mq.delete();
    exp_fetch = 32'h0000_0100;
    exp_pc    = 32'h0000_0100;
    pv = 1'b0; pr = 1'b0; prd = 1'b0; pout = 32'h0; ppc = 32'h0;
    hs_count = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = $urandom;
      imem_gnt       = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      imem_rvalid    = (mq.size() > 0) && ($urandom_range(0, 2) != 0);
      imem_rdata     = imem_rvalid ? memf(mq[0]) : $urandom;
      @(negedge clk);
      if (pv && !pr && !prd) begin
        chk("hold_valid", instr_valid, 32'd1);
        chk("hold_pc",    instr_pc,    ppc);
        chk("hold_out",   instr_out,   pout);
      end
      if (redirect_valid) chk("no_req_on_redirect", imem_req, 32'd0);
      if (imem_req && imem_gnt) begin
        chk("req_addr", imem_addr, exp_fetch);
        mq.push_back(imem_addr);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (instr_valid && instr_ready) begin
        chk("stream_pc",  instr_pc,  exp_pc);
        chk("stream_out", instr_out, memf(exp_pc));
        exp_pc = exp_pc + 32'd4;
        hs_count++;
      end
      if (redirect_valid) begin
        exp_fetch = redirect_pc & 32'hFFFF_FFFC;
        exp_pc    = redirect_pc & 32'hFFFF_FFFC;
      end
      if (imem_rvalid) void'(mq.pop_front());
      pv = instr_valid; pr = instr_ready; prd = redirect_valid;
      pout = instr_out; ppc = instr_pc;
      @(posedge clk);
      #1;
    end
    chk("progress", {31'd0, (hs_count > 500)}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
